// File: rtl/echo_canceller_if.sv
// Sample-stream bundle for echo_canceller: strobed input sample in, strobed cancelled sample out.
// The master side produces input samples; the slave side (the canceller) returns y[n] and warm.
interface echo_canceller_if #(
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] input_sample;
    logic                     out_valid;
    logic signed [DATA_W-1:0] output_sample;
    logic                     warm;

    modport master (
        output in_valid, input_sample,
        input  out_valid, output_sample, warm
    );

    modport slave (
        input  in_valid, input_sample,
        output out_valid, output_sample, warm
    );
endinterface

// File: rtl/echo_canceller.sv
// Single-tap echo canceller: y[n] = x[n] - (x[n-DELAY] >>> SHIFT), delay line in an inferred RAM.
// Define ECHO_CANCEL_SATURATE_EN to clamp the result instead of wrapping it.
module echo_canceller #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 2400,
    parameter int SHIFT  = 8,
    parameter int PTR_W  = 12
) (
    input  logic             sample_clock,
    input  logic             reset_n,
    echo_canceller_if.slave  bus
);
    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    localparam int                 CNT_W     = PTR_W + 1;
    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DELAY - 1);
    localparam logic [CNT_W-1:0]   FILL_DONE = CNT_W'(DELAY);
    localparam logic [DATA_W-1:0]  SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] delay_mem [DELAY];

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] output_sample_q, output_sample_d;

    logic                     mem_we;
    logic signed [DATA_W-1:0] x_d;
    logic signed [DATA_W:0]   x_ext, in_ext, shifted, diff;
    logic signed [DATA_W-1:0] y;

    // Delayed term: the RAM still holds pre-reset samples, so it is masked until the line has refilled.
    always_comb begin
        x_d     = (state_q == RUN) ? delay_mem[wr_ptr_q] : '0;
        x_ext   = {x_d[DATA_W-1], x_d};
        in_ext  = {bus.input_sample[DATA_W-1], bus.input_sample};
        shifted = x_ext >>> SHIFT;
        diff    = in_ext - shifted;
`ifdef ECHO_CANCEL_SATURATE_EN
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            y = diff[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            y = diff[DATA_W-1:0];
        end
`else
        y = diff[DATA_W-1:0];
`endif
    end

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        fill_cnt_d      = fill_cnt_q;
        out_valid_d     = 1'b0;
        output_sample_d = output_sample_q;
        mem_we          = 1'b0;
        if (bus.in_valid) begin
            mem_we          = 1'b1;
            out_valid_d     = 1'b1;
            output_sample_d = y;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (state_q == WARMUP) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_d == FILL_DONE) begin
                    state_d = RUN;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sample_clock) begin
        if (!reset_n) begin
            state_q         <= WARMUP;
            wr_ptr_q        <= '0;
            fill_cnt_q      <= '0;
            out_valid_q     <= 1'b0;
            output_sample_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_cnt_q      <= fill_cnt_d;
            out_valid_q     <= out_valid_d;
            output_sample_q <= output_sample_d;
        end
    end

    // NOTE: the delay RAM has no reset so it maps onto block/distributed RAM; WARMUP hides stale data.
    always_ff @(posedge sample_clock) begin
        if (reset_n && mem_we) begin
            delay_mem[wr_ptr_q] <= bus.input_sample;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.output_sample = output_sample_q;
    assign bus.warm          = (state_q == RUN);
endmodule

// File: tb/tb_echo_canceller.sv
// Directed bench for echo_canceller at DELAY=4, SHIFT=8; each scenario task checks its own results.
module tb_echo_canceller;
    localparam int DATA_W = 16;
    localparam int DELAY  = 4;
    localparam int SHIFT  = 8;
    localparam int PTR_W  = 2;

    logic sample_clock = 1'b0;
    logic reset_n      = 1'b0;
    int   checks       = 0;
    int   errors       = 0;

    echo_canceller_if #(.DATA_W(DATA_W)) bus ();

    echo_canceller #(
        .DATA_W(DATA_W),
        .DELAY (DELAY),
        .SHIFT (SHIFT),
        .PTR_W (PTR_W)
    ) dut (
        .sample_clock(sample_clock),
        .reset_n     (reset_n),
        .bus         (bus)
    );

    always #5 sample_clock = ~sample_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Drive inputs 1 time unit after an edge, then sample registered outputs 1 unit after the next edge.
    task automatic step(input logic valid, input logic signed [DATA_W-1:0] sample);
        bus.in_valid     = valid;
        bus.input_sample = sample;
        @(posedge sample_clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step(1'b0, '0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'sd1000);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.output_sample !== 16'sd0 || bus.warm !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b out=%0d warm=%b, want valid=0 out=0 warm=0",
                         i, bus.out_valid, bus.output_sample, bus.warm);
            end
        end
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_warmup();
        logic signed [DATA_W-1:0] vin [4] = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
        logic                     wexp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vin[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.output_sample !== vin[i] || bus.warm !== wexp[i]) begin
                errors++;
                $display("FAIL warmup[%0d]: got valid=%b out=%0d warm=%b, want valid=1 out=%0d warm=%b",
                         i, bus.out_valid, bus.output_sample, bus.warm, vin[i], wexp[i]);
            end
        end
        step(1'b0, 16'sd7);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.output_sample !== 16'sd400 || bus.warm !== 1'b1) begin
            errors++;
            $display("FAIL warmup_hold: got valid=%b out=%0d warm=%b, want valid=0 out=400 warm=1",
                     bus.out_valid, bus.output_sample, bus.warm);
        end
    endtask

    task automatic test_cancel();
        logic signed [DATA_W-1:0] vin [9] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd64,
                                             16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [DATA_W-1:0] vexp [9] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                                              16'sd0, 16'sd0, 16'sd0, 16'sd0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vin[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.output_sample !== vexp[i]) begin
                errors++;
                $display("FAIL cancel[%0d]: got valid=%b out=%0d, want valid=1 out=%0d",
                         i, bus.out_valid, bus.output_sample, vexp[i]);
            end
        end
    endtask

    task automatic test_echo_removal();
        logic signed [DATA_W-1:0] vexp [10] = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0, -16'sd64,
                                               16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i == 0) ? 16'sd16384 : 16'sd0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.output_sample !== vexp[i]) begin
                errors++;
                $display("FAIL echo_removal[%0d]: got valid=%b out=%0d, want valid=1 out=%0d",
                         i, bus.out_valid, bus.output_sample, vexp[i]);
            end
        end
    endtask

    task automatic test_overflow();
`ifdef ECHO_CANCEL_SATURATE_EN
        logic signed [DATA_W-1:0] ovf_exp = 16'sd32767;
`else
        logic signed [DATA_W-1:0] ovf_exp = -16'sd32641;
`endif
        apply_reset();
        step(1'b1, -16'sd32768);
        checks++;
        if (bus.output_sample !== -16'sd32768) begin
            errors++;
            $display("FAIL overflow_first: got out=%0d, want out=-32768", bus.output_sample);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 16'sd0);
        step(1'b1, 16'sd32767);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.output_sample !== ovf_exp) begin
            errors++;
            $display("FAIL overflow: got valid=%b out=%0d, want valid=1 out=%0d",
                     bus.out_valid, bus.output_sample, ovf_exp);
        end
    endtask

    task automatic test_gap_hold();
        apply_reset();
        step(1'b1, 16'sd500);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, -16'sd1234);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.output_sample !== 16'sd500) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got valid=%b out=%0d, want valid=0 out=500",
                         i, bus.out_valid, bus.output_sample);
            end
        end
        step(1'b1, -16'sd7);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.output_sample !== -16'sd7) begin
            errors++;
            $display("FAIL gap_resume: got valid=%b out=%0d, want valid=1 out=-7",
                     bus.out_valid, bus.output_sample);
        end
    endtask

    task automatic test_midstream_reset();
        logic wexp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'sd8000);
        reset_n = 1'b0;
        step(1'b1, 16'sd8000);
        reset_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.output_sample !== 16'sd0 || bus.warm !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pulse: got valid=%b out=%0d warm=%b, want valid=0 out=0 warm=0",
                     bus.out_valid, bus.output_sample, bus.warm);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'sd8000);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.output_sample !== 16'sd8000 || bus.warm !== wexp[i]) begin
                errors++;
                $display("FAIL midreset[%0d]: got valid=%b out=%0d warm=%b, want valid=1 out=8000 warm=%b",
                         i, bus.out_valid, bus.output_sample, bus.warm, wexp[i]);
            end
        end
        // 8000 - (8000 >>> 8) = 8000 - 31
        step(1'b1, 16'sd8000);
        checks++;
        if (bus.output_sample !== 16'sd7969 || bus.warm !== 1'b1) begin
            errors++;
            $display("FAIL midreset_run: got out=%0d warm=%b, want out=7969 warm=1",
                     bus.output_sample, bus.warm);
        end
        step(1'b0, '0);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.input_sample = '0;
        test_reset();
        test_warmup();
        test_cancel();
        test_echo_removal();
        test_overflow();
        test_gap_hold();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
